// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - multi-lane circular instruction buffer with decode predecode
module decode_queue #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 2,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IN_W-1:0]        fetch_valid,
  input  logic [IN_W-1:0]        fetch_error,
  input  logic [IN_W*31-1:0]     fetch_addr,
  input  logic [IN_W*32-1:0]     fetch_insn,
  input  logic [IN_W*16-1:0]     fetch_bptag,
  input  logic [IN_W-1:0]        fetch_bptaken,
  output logic                   queue_ready,
  input  logic                   rob_flush,
  output logic [OUT_W-1:0]       out_valid,
  output logic [OUT_W-1:0]       out_error,
  output logic [OUT_W*31-1:0]    out_addr,
  output logic [OUT_W*32-1:0]    out_insn,
  output logic [OUT_W*16-1:0]    out_bptag,
  output logic [OUT_W-1:0]       out_bptaken,
  output logic [OUT_W-1:0]       out_illegal,
  output logic [OUT_W*6-1:0]     out_rd,
  input  logic [$clog2(OUT_W+1)-1:0] dec_take,
  output logic [CW-1:0]          queue_count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  // Entry storage; never reset, validity is tracked by count alone
  logic          mem_error   [DEPTH];
  logic [30:0]   mem_addr    [DEPTH];
  logic [31:0]   mem_insn    [DEPTH];
  logic [15:0]   mem_bptag   [DEPTH];
  logic          mem_bptaken [DEPTH];

  logic [IN_W-1:0] push_lane;
  logic [CW-1:0]   push_k;
  logic [CW-1:0]   push_eff;
  logic            run;
  logic [CW-1:0]   avail;
  logic [CW-1:0]   take_eff;
  logic [31:0]     lane_insn [OUT_W];
  logic            lane_legal [OUT_W];
  logic            lane_uses_rd [OUT_W];

  function automatic logic op_legal(input logic [6:0] op);
    logic ok;
    ok = 1'b0;
    if (op[1:0] == 2'b11) begin
      case (op[6:2])
        5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
        5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100: ok = 1'b1;
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Only the contiguous run of valid lanes starting at lane 0 is accepted
  always_comb begin
    push_lane = '0;
    push_k    = '0;
    run       = 1'b1;
    for (int i = 0; i < IN_W; i++) begin
      run          = run & fetch_valid[i];
      push_lane[i] = run;
      if (run) push_k = push_k + CW'(1);
    end
  end

  // Readiness from registered count only, so fetch never waits on decode this cycle
  assign queue_ready = (CW'(DEPTH) - count) >= CW'(IN_W);
  assign push_eff    = queue_ready ? push_k : '0;
  assign avail       = (count > CW'(OUT_W)) ? CW'(OUT_W) : count;
  assign take_eff    = (CW'(dec_take) > avail) ? avail : CW'(dec_take);
  assign queue_count = count;

  // Pointer and occupancy update; reset beats flush, flush beats push/pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rob_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + push_eff[PW-1:0];
      head  <= head + take_eff[PW-1:0];
      count <= count + push_eff - take_eff;
    end
  end

  // Write accepted fetch lanes at tail onward, wrapping through the ring
  always_ff @(posedge clk) begin
    if (rst_n && !rob_flush && queue_ready) begin
      for (int i = 0; i < IN_W; i++) begin
        if (push_lane[i]) begin
          mem_error[tail + PW'(i)]   <= fetch_error[i];
          mem_addr[tail + PW'(i)]    <= fetch_addr[i*31 +: 31];
          mem_insn[tail + PW'(i)]    <= fetch_insn[i*32 +: 32];
          mem_bptag[tail + PW'(i)]   <= fetch_bptag[i*16 +: 16];
          mem_bptaken[tail + PW'(i)] <= fetch_bptaken[i];
        end
      end
    end
  end

  // Present the oldest OUT_W entries with legality and destination predecode
  always_comb begin
    out_valid   = '0;
    out_error   = '0;
    out_addr    = '0;
    out_insn    = '0;
    out_bptag   = '0;
    out_bptaken = '0;
    out_illegal = '0;
    out_rd      = '0;
    for (int i = 0; i < OUT_W; i++) begin
      lane_insn[i]    = mem_insn[head + PW'(i)];
      lane_legal[i]   = op_legal(lane_insn[i][6:0]);
      lane_uses_rd[i] = lane_legal[i] && (lane_insn[i][6:2] != 5'b01000) &&
                        (lane_insn[i][6:2] != 5'b11000) && (lane_insn[i][11:7] != 5'd0);
      out_valid[i]          = count > CW'(i);
      out_error[i]          = mem_error[head + PW'(i)];
      out_addr[i*31 +: 31]  = mem_addr[head + PW'(i)];
      out_insn[i*32 +: 32]  = lane_insn[i];
      out_bptag[i*16 +: 16] = mem_bptag[head + PW'(i)];
      out_bptaken[i]        = mem_bptaken[head + PW'(i)];
      out_illegal[i]        = ~lane_legal[i];
      out_rd[i*6 +: 6]      = {~lane_uses_rd[i], lane_insn[i][11:7]};
    end
  end

  // Flag protocol violations from fetch and decode in simulation
  always_ff @(posedge clk) begin
    if (rst_n && !rob_flush) begin
      assert ((fetch_valid & (fetch_valid + IN_W'(1))) == '0);
      assert (CW'(dec_take) <= avail);
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - randomized scoreboard bench for decode_queue
module tb_decode_queue;

  localparam int IN_W  = 2;
  localparam int OUT_W = 2;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int TW    = $clog2(OUT_W + 1);

  logic                clk = 1'b0;
  logic                rst_n;
  logic [IN_W-1:0]     fetch_valid;
  logic [IN_W-1:0]     fetch_error;
  logic [IN_W*31-1:0]  fetch_addr;
  logic [IN_W*32-1:0]  fetch_insn;
  logic [IN_W*16-1:0]  fetch_bptag;
  logic [IN_W-1:0]     fetch_bptaken;
  logic                queue_ready;
  logic                rob_flush;
  logic [OUT_W-1:0]    out_valid;
  logic [OUT_W-1:0]    out_error;
  logic [OUT_W*31-1:0] out_addr;
  logic [OUT_W*32-1:0] out_insn;
  logic [OUT_W*16-1:0] out_bptag;
  logic [OUT_W-1:0]    out_bptaken;
  logic [OUT_W-1:0]    out_illegal;
  logic [OUT_W*6-1:0]  out_rd;
  logic [TW-1:0]       dec_take;
  logic [CW-1:0]       queue_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference queue: entry = {error, addr[30:0], insn, bptag, bptaken}
  logic [80:0] mq[$];
  logic [6:0]  legal_ops [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                  7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

  decode_queue #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_error(fetch_error), .fetch_addr(fetch_addr),
    .fetch_insn(fetch_insn), .fetch_bptag(fetch_bptag), .fetch_bptaken(fetch_bptaken),
    .queue_ready(queue_ready), .rob_flush(rob_flush),
    .out_valid(out_valid), .out_error(out_error), .out_addr(out_addr),
    .out_insn(out_insn), .out_bptag(out_bptag), .out_bptaken(out_bptaken),
    .out_illegal(out_illegal), .out_rd(out_rd), .dec_take(dec_take),
    .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic ref_illegal(input logic [31:0] insn);
    logic found;
    found = 1'b0;
    foreach (legal_ops[j]) if (insn[6:0] == legal_ops[j]) found = 1'b1;
    return !found;
  endfunction

  function automatic logic [5:0] ref_rd(input logic [31:0] insn);
    logic uses;
    uses = !ref_illegal(insn) && insn[6:0] != 7'h23 && insn[6:0] != 7'h63 && insn[11:7] != 5'd0;
    return {!uses, insn[11:7]};
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] r;
    int unsigned sel;
    r   = $urandom;
    sel = $urandom_range(3, 0);
    if (sel != 0) r[6:0] = legal_ops[$urandom_range(10, 0)];
    return r;
  endfunction

  task automatic model_update();
    int sz;
    bit ready;
    sz = mq.size();
    ready = (DEPTH - sz) >= IN_W;
    if (!rst_n || rob_flush) begin
      mq.delete();
    end else begin
      for (int i = 0; i < int'(dec_take) && mq.size() > 0 && i < OUT_W; i++) void'(mq.pop_front());
      if (ready) begin
        for (int i = 0; i < IN_W; i++) begin
          if (!fetch_valid[i]) break;
          mq.push_back({fetch_error[i], fetch_addr[i*31 +: 31], fetch_insn[i*32 +: 32],
                        fetch_bptag[i*16 +: 16], fetch_bptaken[i]});
        end
      end
    end
  endtask

  task automatic check_outputs();
    int sz;
    logic [80:0] e;
    sz = mq.size();
    check("queue_count", queue_count, sz);
    check("queue_ready", queue_ready, (DEPTH - sz) >= IN_W);
    for (int i = 0; i < OUT_W; i++) begin
      check($sformatf("lane%0d_valid", i), out_valid[i], i < sz);
      if (i < sz) begin
        e = mq[i];
        check($sformatf("lane%0d_error", i), out_error[i], e[80]);
        check($sformatf("lane%0d_addr", i), out_addr[i*31 +: 31], e[79:49]);
        check($sformatf("lane%0d_insn", i), out_insn[i*32 +: 32], e[48:17]);
        check($sformatf("lane%0d_bptag", i), out_bptag[i*16 +: 16], e[16:1]);
        check($sformatf("lane%0d_bptaken", i), out_bptaken[i], e[0]);
        check($sformatf("lane%0d_illegal", i), out_illegal[i], ref_illegal(e[48:17]));
        check($sformatf("lane%0d_rd", i), out_rd[i*6 +: 6], ref_rd(e[48:17]));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive_lane(input int i, input logic err, input logic [30:0] a,
                            input logic [31:0] ins);
    logic [31:0] r;
    r = $urandom;
    fetch_error[i]          = err;
    fetch_addr[i*31 +: 31]  = a;
    fetch_insn[i*32 +: 32]  = ins;
    fetch_bptag[i*16 +: 16] = r[15:0];
    fetch_bptaken[i]        = r[16];
  endtask

  task automatic drive_rand(input int n);
    logic [31:0] r;
    for (int i = 0; i < IN_W; i++) begin
      r = $urandom;
      drive_lane(i, r[31], r[30:0], rand_insn());
    end
    fetch_valid = IN_W'((1 << n) - 1);
  endtask

  task automatic idle();
    fetch_valid = '0;
    dec_take    = '0;
    rob_flush   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    fetch_error = '0; fetch_addr = '0; fetch_insn = '0; fetch_bptag = '0; fetch_bptaken = '0;
    @(negedge clk);
    cycle();
    cycle();
    check("rst_count", queue_count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ready", queue_ready, 1);
    rst_n = 1'b1;

    // First push and predecode of addi x1 / nop
    drive_lane(0, 1'b0, 31'h0000_0800, 32'h00A0_0093);
    drive_lane(1, 1'b0, 31'h0000_0802, 32'h0000_0013);
    fetch_valid = 2'b11;
    cycle();
    idle();
    check("t1_valid", out_valid, 2'b11);
    check("t1_rd", out_rd, 12'b100000_000001);
    check("t1_illegal", out_illegal, 2'b00);
    check("t1_count", queue_count, 2);

    // Fill to full, then offer one more push
    for (int j = 0; j < 3; j++) begin
      drive_rand(2);
      cycle();
      check("t2_count", queue_count, 4 + 2 * j);
    end
    check("t2_full_ready", queue_ready, 0);
    drive_rand(2);
    cycle();
    check("t2_overflow_count", queue_count, 8);
    idle();

    // Steady push 2 / take 2 through pointer wrap
    rob_flush = 1'b1;
    cycle();
    idle();
    for (int j = 0; j < 11; j++) begin
      drive_lane(0, 1'b0, 31'((32'h1000 + 8 * j) >> 1), 32'h0000_0013);
      drive_lane(1, 1'b0, 31'((32'h1004 + 8 * j) >> 1), 32'h0000_0013);
      fetch_valid = 2'b11;
      dec_take    = (j == 0) ? 2'd0 : 2'd2;
      cycle();
      check("t3_count", queue_count, 2);
      check("t3_order", out_addr[30:0], 31'((32'h1000 + 8 * j) >> 1));
    end
    idle();

    // Flush with count 5 and a simultaneous push
    rob_flush = 1'b1;
    cycle();
    idle();
    drive_rand(2); cycle();
    drive_rand(2); cycle();
    drive_rand(1); cycle();
    check("t4_pre_count", queue_count, 5);
    drive_rand(2);
    rob_flush = 1'b1;
    cycle();
    idle();
    check("t4_count", queue_count, 0);
    check("t4_valid", out_valid, 0);
    check("t4_ready", queue_ready, 1);

    // Illegal encodings and fetch fault passthrough
    drive_lane(0, 1'b0, 31'h10, 32'h0000_000B);
    drive_lane(1, 1'b0, 31'h12, 32'h0000_0001);
    fetch_valid = 2'b11;
    cycle();
    idle();
    check("t5_illegal", out_illegal, 2'b11);
    check("t5_rd5", out_rd[5], 1'b1);
    dec_take = 2'd2;
    drive_lane(0, 1'b1, 31'h14, 32'h0000_0013);
    fetch_valid = 2'b01;
    cycle();
    idle();
    check("t5_error", out_error[0], 1'b1);
    check("t5_err_illegal", out_illegal[0], 1'b0);

    // Reset mid-stream with count 6 and a pending take
    rob_flush = 1'b1;
    cycle();
    idle();
    for (int j = 0; j < 3; j++) begin drive_rand(2); cycle(); end
    check("t6_pre_count", queue_count, 6);
    idle();
    rst_n    = 1'b0;
    dec_take = 2'd2;
    cycle();
    rst_n = 1'b1;
    idle();
    check("t6_count", queue_count, 0);
    check("t6_valid", out_valid, 0);
    drive_rand(2);
    cycle();
    idle();
    check("t6_resume_count", queue_count, 2);

    // Random traffic
    for (int j = 0; j < 600; j++) begin
      int sz;
      int mx;
      sz = mq.size();
      mx = (sz < OUT_W) ? sz : OUT_W;
      drive_rand($urandom_range(IN_W, 0));
      dec_take  = TW'($urandom_range(mx, 0));
      rob_flush = ($urandom_range(31, 0) == 0);
      rst_n     = ($urandom_range(63, 0) != 0);
      cycle();
    end
    idle();
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
